fp_round_pipe: RTL and testbench
================================

# fp_round_pipe

Parametrised, two-stage pipelined IEEE-754 rounding unit for the FPU datapath. It sits after normalisation and before result packing. It takes a normalised sign/exponent/extended mantissa carrying guard/round/sticky bits and produces the rounded exponent and fraction. Compared with the single-cycle rounder it adds a valid/ready handshake with backpressure, round-to-nearest-ties-away, post-rounding exponent overflow saturation, special-value passthrough and optional exception flags.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, stored fraction width (hidden bit excluded)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- in_sign  in  1  sign
- in_exp  in  EXP_W  biased exponent
- in_mant  in  MAN_W+5  bit layout:
  - [MAN_W+4]: headroom, must be 0
  - [MAN_W+3]: hidden bit
  - [MAN_W+2:3]: fraction
  - [2]: G, [1]: R, [0]: S
- in_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RUP, 011 RDN, 100 RMM; 101–111 behave as RNE
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sign  out  1  sign, passed through unchanged
- out_exp  out  EXP_W  rounded exponent
- out_mant  out  MAN_W  rounded fraction
- out_inexact  out  1  G|R|S was nonzero (only with FP_ROUND_FLAGS_EN)
- out_overflow  out  1  rounding overflowed the finite range (only with FP_ROUND_FLAGS_EN)

## Operation
- Beat transfer: a beat moves on in_valid&in_ready. A result moves on out_valid&out_ready.
- Stage 1 (increment decision and add):
  - RNE: inc = G&(R|S|L), where L = in_mant[3].
  - RMM: inc = G.
  - RTZ: inc = 0.
  - RUP: inc = ~sign&(G|R|S).
  - RDN: inc = sign&(G|R|S).
  - sum = in_mant[MAN_W+4:3] + inc, width MAN_W+2.
  - Register sign, exp, sum, inexact and the special flag.
- Stage 2 (renormalise and saturate):
  - If sum[MAN_W+1]=1: shift sum right by 1 and add 1 to exp.
  - If sum is not carried and hidden=1 with exp=0 (a subnormal rounded up to normal): exp becomes 1.
- Overflow: rounding produced exp = all-ones from a finite input.
  - RNE, RMM: result is ±inf (exp all-ones, frac 0).
  - RUP: +inf when positive, max finite (exp all-ones−1, frac all-ones) when negative.
  - RDN: −inf when negative, max finite when positive.
  - RTZ never increments, so it never overflows.
- Special input (in_exp all-ones, inf/NaN): exp and fraction pass through untouched. inexact and overflow are 0.
- Zero input (exp 0, mantissa 0): passes through as ±0.

## Timing
- Latency is 2 cycles from input acceptance to out_valid, with no stall.
- Throughput is 1 beat per cycle.
- Ready logic:
  - s2_ready = ~s2_valid | out_ready.
  - s1_ready = ~s1_valid | s2_ready.
  - in_ready = s1_ready. This is combinational from out_ready; the path is permitted.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.
- At most 2 beats are in flight. Order is preserved.
- Reset values: all outputs 0, in_ready 1 after reset deasserts. Both stage valids are 0.
- Reset mid-operation discards in-flight beats immediately. Nothing is emitted afterwards.
- Simultaneous accept and emit in the same cycle with a full pipeline is a legal pass-through and causes no bubble.

## Configuration
- Macro: FP_ROUND_FLAGS_EN.
  - Defined: out_inexact and out_overflow ports exist. They are pipelined alongside the data and held under stall.
  - Undefined: the ports and their flops are absent. Data behaviour is identical.

## Structure
- Shared package fp_pkg holds:
  - rounding mode localparams (RM_RNE, RM_RTZ, RM_RUP, RM_RDN, RM_RMM);
  - default EXP_W/MAN_W;
  - helper constants for exp all-ones and max-finite.
- One combinational sub-module, fp_round_decide, takes mode, sign, L, G, R, S and returns inc. The future divide/sqrt rounders reuse it.

## Test plan
- RNE tie-to-even: exp 0x80, frac 0x000001, GRS 100 → frac 0x000002, inexact 1. Same with frac 0x000000 → frac 0x000000, inexact 1.
- Carry renormalise: RNE, exp 0x80, frac 0x7FFFFF, GRS 110 → exp 0x81, frac 0x000000.
- Overflow per mode, exp 0xFE, frac 0x7FFFFF, GRS 111:
  - RNE → exp 0xFF, frac 0, overflow 1.
  - RUP with sign 1 → exp 0xFE, frac 0x7FFFFF, overflow 0.
  - RMM with sign 0 → +inf.
- Backpressure: hold out_ready=0 and offer 3 beats → exactly 2 accepted, in_ready=0, out_* stable. Release → 3 results in order, no duplicates.
- Special passthrough: exp 0xFF, frac 0x400000 (NaN), GRS 111, RUP → exp 0xFF, frac 0x400000, inexact 0.
- Reset mid-flight: pulse rst with 2 beats in flight → out_valid 0 next cycle, outputs 0, in_ready 1, no stale result afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FPU rounding definitions: rounding-mode encodings, default field widths
// and the exponent/fraction constants used for overflow saturation.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RUP = 3'b010;
    localparam logic [2:0] RM_RDN = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [FP_EXP_W-1:0] FP_EXP_ONES    = {FP_EXP_W{1'b1}};
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX_FIN = FP_EXP_ONES - {{(FP_EXP_W-1){1'b0}}, 1'b1};
    localparam logic [FP_MAN_W-1:0] FP_FRAC_ONES   = {FP_MAN_W{1'b1}};

    // Reserved encodings 101..111 fold onto round-to-nearest-even.
    function automatic logic [2:0] rm_canon(input logic [2:0] mode);
        logic [2:0] m;
        case (mode)
            RM_RNE, RM_RTZ, RM_RUP, RM_RDN, RM_RMM: m = mode;
            default:                                m = RM_RNE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational round-increment decision from mode, sign and the L/G/R/S bits;
// shared with the divide/sqrt rounders.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic [2:0] mode_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       g_i,
    input  logic       r_i,
    input  logic       s_i,
    output logic       inc_o
);

    // Increment decision per rounding mode
    always_comb begin
        inc_o = 1'b0;
        case (mode_i)
            RM_RNE:  inc_o = g_i & (r_i | s_i | lsb_i);
            RM_RTZ:  inc_o = 1'b0;
            RM_RUP:  inc_o = ~sign_i & (g_i | r_i | s_i);
            RM_RDN:  inc_o = sign_i & (g_i | r_i | s_i);
            RM_RMM:  inc_o = g_i;
            default: inc_o = g_i & (r_i | s_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined IEEE-754 rounder with valid/ready backpressure.
// Define FP_ROUND_FLAGS_EN to add the out_inexact/out_overflow flag ports.
module fp_round_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+4:0] in_mant,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_mant
`ifdef FP_ROUND_FLAGS_EN
    ,
    output logic             out_inexact,
    output logic             out_overflow
`endif
);

    localparam int               SUM_W     = MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_MAXF  = EXP_ONES - EXP_ONE;
    localparam logic [MAN_W-1:0] FRAC_ONES = {MAN_W{1'b1}};
    localparam logic [MAN_W-1:0] FRAC_ZERO = {MAN_W{1'b0}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SUM_W-1:0] sum;
        logic             special;
        logic [2:0]       mode;
`ifdef FP_ROUND_FLAGS_EN
        logic             inexact;
`endif
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
`ifdef FP_ROUND_FLAGS_EN
        logic             inexact;
        logic             overflow;
`endif
    } out_t;

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d, s1_new_s;
    logic             out_valid_q, out_valid_d;
    out_t             out_q, out_d, out_new_s;

    logic             s1_ready_s, s2_ready_s, accept_s, advance_s;
    logic             special_s, inc_raw_s, inc_s;
    logic [2:0]       mode_s;
    logic [SUM_W-1:0] sum_s;
    logic [EXP_W-1:0] exp_n_s;
    logic [MAN_W-1:0] frac_n_s;
    logic             ovf_s;

    assign s2_ready_s = ~out_valid_q | out_ready;
    assign s1_ready_s = ~s1_valid_q | s2_ready_s;
    assign in_ready   = s1_ready_s;
    assign accept_s   = in_valid & s1_ready_s;
    assign advance_s  = s1_valid_q & s2_ready_s;

    assign mode_s    = rm_canon(in_mode);
    assign special_s = (in_exp == EXP_ONES);

    fp_round_decide u_decide (
        .mode_i (mode_s),
        .sign_i (in_sign),
        .lsb_i  (in_mant[3]),
        .g_i    (in_mant[2]),
        .r_i    (in_mant[1]),
        .s_i    (in_mant[0]),
        .inc_o  (inc_raw_s)
    );

    // Inf/NaN never round, so their fraction passes through bit-exact.
    assign inc_s = inc_raw_s & ~special_s;
    assign sum_s = in_mant[MAN_W+4:3] + {{(SUM_W-1){1'b0}}, inc_s};

    // Stage-1 payload assembled from the incoming beat
    always_comb begin
        s1_new_s         = {$bits(s1_t){1'b0}};
        s1_new_s.sign    = in_sign;
        s1_new_s.exp     = in_exp;
        s1_new_s.sum     = sum_s;
        s1_new_s.special = special_s;
        s1_new_s.mode    = mode_s;
`ifdef FP_ROUND_FLAGS_EN
        s1_new_s.inexact = (|in_mant[2:0]) & ~special_s;
`endif
    end

    // Stage-2 renormalisation and overflow saturation
    always_comb begin
        exp_n_s  = s1_q.exp;
        frac_n_s = s1_q.sum[MAN_W-1:0];
        ovf_s    = 1'b0;
        if (s1_q.special) begin
            exp_n_s  = s1_q.exp;
            frac_n_s = s1_q.sum[MAN_W-1:0];
        end else if (s1_q.sum[MAN_W+1]) begin
            exp_n_s  = s1_q.exp + EXP_ONE;
            frac_n_s = s1_q.sum[MAN_W:1];
        end else if (s1_q.sum[MAN_W] && (s1_q.exp == EXP_ZERO)) begin
            exp_n_s  = EXP_ONE;
            frac_n_s = s1_q.sum[MAN_W-1:0];
        end else begin
            exp_n_s  = s1_q.exp;
            frac_n_s = s1_q.sum[MAN_W-1:0];
        end

        ovf_s = ~s1_q.special & (exp_n_s == EXP_ONES);
        if (ovf_s) begin
            case (s1_q.mode)
                RM_RUP: begin
                    exp_n_s  = s1_q.sign ? EXP_MAXF  : EXP_ONES;
                    frac_n_s = s1_q.sign ? FRAC_ONES : FRAC_ZERO;
                end
                RM_RDN: begin
                    exp_n_s  = s1_q.sign ? EXP_ONES  : EXP_MAXF;
                    frac_n_s = s1_q.sign ? FRAC_ZERO : FRAC_ONES;
                end
                default: begin
                    exp_n_s  = EXP_ONES;
                    frac_n_s = FRAC_ZERO;
                end
            endcase
        end else begin
            frac_n_s = frac_n_s;
        end

        out_new_s          = {$bits(out_t){1'b0}};
        out_new_s.sign     = s1_q.sign;
        out_new_s.exp      = exp_n_s;
        out_new_s.mant     = frac_n_s;
`ifdef FP_ROUND_FLAGS_EN
        out_new_s.inexact  = s1_q.inexact;
        out_new_s.overflow = ovf_s;
`endif
    end

    // Handshake-controlled next state for both pipeline stages
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s1_ready_s) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (accept_s) begin
            s1_d = s1_new_s;
        end else begin
            s1_d = s1_q;
        end
        if (s2_ready_s) begin
            out_valid_d = s1_valid_q;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (advance_s) begin
            out_d = out_new_s;
        end else begin
            out_d = out_q;
        end
    end

    // Pipeline registers; reset drops any in-flight beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= {$bits(s1_t){1'b0}};
            out_valid_q <= 1'b0;
            out_q       <= {$bits(out_t){1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_q.sign;
    assign out_exp   = out_q.exp;
    assign out_mant  = out_q.mant;
`ifdef FP_ROUND_FLAGS_EN
    assign out_inexact  = out_q.inexact;
    assign out_overflow = out_q.overflow;
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe: directed vector table, hand-written
// backpressure/reset sequences and randomized beats against a value-level model.
module tb_fp_round_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'h00;
    logic [27:0] in_mant = 28'h0;
    logic [2:0]  in_mode = 3'b000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
`ifdef FP_ROUND_FLAGS_EN
    logic        out_inexact;
    logic        out_overflow;
`endif

    fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant)
`ifdef FP_ROUND_FLAGS_EN
        ,
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        inx;
        logic        ovf;
    } res_t;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic [2:0]  mode;
        res_t        r;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   emit_cnt = 0;
    res_t expq[$];
    logic rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [27:0] mk(input logic hid, input logic [22:0] f, input logic [2:0] grs);
        return {1'b0, hid, f, grs};
    endfunction

    function automatic res_t mkres(input logic s, input logic [7:0] e, input logic [22:0] f,
                                   input logic i, input logic o);
        res_t r;
        r.sign = s; r.exp = e; r.frac = f; r.inx = i; r.ovf = o;
        return r;
    endfunction

    // Reference: treat the mantissa as an integer scaled by 8 and round by value.
    function automatic res_t model(input logic s, input logic [7:0] e, input logic [27:0] m,
                                   input logic [2:0] md);
        res_t        r;
        int unsigned q, rem, eo, eff;
        bit          up, to_inf;
        eff = (md > 3'd4) ? 0 : int'(md);
        r.sign = s;
        if (e == 8'hFF) begin
            r.exp = e; r.frac = m[25:3]; r.inx = 1'b0; r.ovf = 1'b0;
            return r;
        end
        q   = m >> 3;
        rem = m & 28'd7;
        case (eff)
            0:       up = (rem > 4) || (rem == 4 && (q % 2) == 1);
            1:       up = 1'b0;
            2:       up = !s && rem != 0;
            3:       up = s && rem != 0;
            default: up = rem >= 4;
        endcase
        q  = q + (up ? 1 : 0);
        eo = e;
        if (q >= (1 << 24)) begin
            q  = q / 2;
            eo = eo + 1;
        end else if (eo == 0 && q >= (1 << 23)) begin
            eo = 1;
        end
        r.inx = (rem != 0);
        r.ovf = 1'b0;
        if (eo == 255) begin
            r.ovf  = 1'b1;
            to_inf = (eff == 2) ? !s : (eff == 3) ? s : 1'b1;
            r.exp  = to_inf ? 8'hFF : 8'hFE;
            r.frac = to_inf ? 23'h0 : 23'h7FFFFF;
        end else begin
            r.exp  = eo[7:0];
            r.frac = q[22:0];
        end
        return r;
    endfunction

    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                        input logic [2:0] md, input res_t r);
        int n;
        n = 0;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_mode = md;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (in_ready) begin
            expq.push_back(r);
        end else begin
            total++; bad++;
            $display("FAIL accept_timeout: actual=in_ready 0 required=in_ready 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", expq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        res_t        e;
        logic [31:0] snap;
        logic        stall_prev;
        stall_prev = 1'b0;
        snap = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", {out_sign, out_exp, out_mant}, snap);
                end
                if (out_valid && out_ready) begin
                    emit_cnt++;
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL spurious_result: actual=%0h required=none",
                                 {out_sign, out_exp, out_mant});
                    end else begin
                        e = expq.pop_front();
                        chk("result", {out_sign, out_exp, out_mant}, {e.sign, e.exp, e.frac});
`ifdef FP_ROUND_FLAGS_EN
                        chk("flags", {out_inexact, out_overflow}, {e.inx, e.ovf});
`endif
                    end
                end
                stall_prev = out_valid && !out_ready;
                snap = {out_sign, out_exp, out_mant};
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : main
        vec_t        tbl[$];
        int          base;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [2:0]  md;
        logic [27:0] m;

        tbl.push_back('{1'b0, 8'h80, mk(1'b1, 23'h000001, 3'b100), RM_RNE, mkres(1'b0, 8'h80, 23'h000002, 1'b1, 1'b0)});
        tbl.push_back('{1'b0, 8'h80, mk(1'b1, 23'h000000, 3'b100), RM_RNE, mkres(1'b0, 8'h80, 23'h000000, 1'b1, 1'b0)});
        tbl.push_back('{1'b0, 8'h80, mk(1'b1, 23'h7FFFFF, 3'b110), RM_RNE, mkres(1'b0, 8'h81, 23'h000000, 1'b1, 1'b0)});
        tbl.push_back('{1'b0, 8'hFE, mk(1'b1, 23'h7FFFFF, 3'b111), RM_RNE, mkres(1'b0, 8'hFF, 23'h000000, 1'b1, 1'b1)});
        tbl.push_back('{1'b1, 8'hFE, mk(1'b1, 23'h7FFFFF, 3'b111), RM_RUP, mkres(1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0)});
        tbl.push_back('{1'b0, 8'hFE, mk(1'b1, 23'h7FFFFF, 3'b111), RM_RMM, mkres(1'b0, 8'hFF, 23'h000000, 1'b1, 1'b1)});
        tbl.push_back('{1'b0, 8'hFF, mk(1'b1, 23'h400000, 3'b111), RM_RUP, mkres(1'b0, 8'hFF, 23'h400000, 1'b0, 1'b0)});
        tbl.push_back('{1'b1, 8'h00, mk(1'b0, 23'h000000, 3'b000), RM_RUP, mkres(1'b1, 8'h00, 23'h000000, 1'b0, 1'b0)});
        tbl.push_back('{1'b0, 8'h00, mk(1'b0, 23'h7FFFFF, 3'b110), RM_RNE, mkres(1'b0, 8'h01, 23'h000000, 1'b1, 1'b0)});
        tbl.push_back('{1'b0, 8'h80, mk(1'b1, 23'h123456, 3'b111), RM_RTZ, mkres(1'b0, 8'h80, 23'h123456, 1'b1, 1'b0)});
        tbl.push_back('{1'b1, 8'h80, mk(1'b1, 23'h000000, 3'b001), RM_RDN, mkres(1'b1, 8'h80, 23'h000001, 1'b1, 1'b0)});
        tbl.push_back('{1'b0, 8'h80, mk(1'b1, 23'h000003, 3'b100), 3'b111, mkres(1'b0, 8'h80, 23'h000004, 1'b1, 1'b0)});
        tbl.push_back('{1'b0, 8'h80, mk(1'b1, 23'h000002, 3'b100), RM_RMM, mkres(1'b0, 8'h80, 23'h000003, 1'b1, 1'b0)});
        tbl.push_back('{1'b1, 8'hFE, mk(1'b1, 23'h7FFFFF, 3'b001), RM_RDN, mkres(1'b1, 8'hFF, 23'h000000, 1'b1, 1'b1)});
        tbl.push_back('{1'b0, 8'hFE, mk(1'b1, 23'h7FFFFF, 3'b001), RM_RUP, mkres(1'b0, 8'hFF, 23'h000000, 1'b1, 1'b1)});
        tbl.push_back('{1'b0, 8'h80, mk(1'b1, 23'h000000, 3'b010), RM_RUP, mkres(1'b0, 8'h80, 23'h000001, 1'b1, 1'b0)});

        // Reset state while rst is held, then just after release
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", {out_sign, out_exp, out_mant}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;

        // Two-cycle latency with no stall
        out_ready = 1'b1;
        send(tbl[0].sign, tbl[0].exp, tbl[0].mant, tbl[0].mode, tbl[0].r);
        @(negedge clk);
        chk("latency_c1", out_valid, 0);
        @(negedge clk);
        chk("latency_c2", out_valid, 1);
        drain();

        // Directed vector table, back to back
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].sign, tbl[i].exp, tbl[i].mant, tbl[i].mode, tbl[i].r);
        end
        drain();

        // Backpressure: two beats fill the pipe, the third must wait
        out_ready = 1'b0;
        base = emit_cnt;
        send(1'b0, 8'h10, mk(1'b1, 23'h000011, 3'b101), RM_RNE, model(1'b0, 8'h10, mk(1'b1, 23'h000011, 3'b101), RM_RNE));
        send(1'b1, 8'h20, mk(1'b1, 23'h000022, 3'b011), RM_RDN, model(1'b1, 8'h20, mk(1'b1, 23'h000022, 3'b011), RM_RDN));
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h30; in_mant = mk(1'b1, 23'h000033, 3'b100); in_mode = RM_RMM;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        chk("bp_no_emit", emit_cnt - base, 0);
        out_ready = 1'b1;
        send(1'b0, 8'h30, mk(1'b1, 23'h000033, 3'b100), RM_RMM, model(1'b0, 8'h30, mk(1'b1, 23'h000033, 3'b100), RM_RMM));
        drain();
        chk("bp_emit_count", emit_cnt - base, 3);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(1'b0, 8'h40, mk(1'b1, 23'h000044, 3'b111), RM_RUP, model(1'b0, 8'h40, mk(1'b1, 23'h000044, 3'b111), RM_RUP));
        send(1'b1, 8'h50, mk(1'b1, 23'h000055, 3'b111), RM_RDN, model(1'b1, 8'h50, mk(1'b1, 23'h000055, 3'b111), RM_RDN));
        rst = 1'b1;
        expq.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", {out_sign, out_exp, out_mant}, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        base = emit_cnt;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_stale", emit_cnt - base, 0);
        @(posedge clk); #1;

        // Randomized beats with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       e = 8'h00;
                1:       e = 8'hFE;
                2:       e = 8'hFF;
                3:       e = 8'h01;
                default: e = 8'($urandom_range(1, 254));
            endcase
            f  = ($urandom_range(0, 2) == 0) ? 23'h7FFFFF : 23'($urandom);
            md = 3'($urandom_range(0, 7));
            m  = mk(e != 8'h00, f, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
            send(s, e, m, md, model(s, e, m, md));
        end
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
